// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller sharing one full-adder cell, LSB first
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_FEEDER = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic             w_sum_bit;
  logic             w_carry_out;
  logic [WIDTH-1:0] w_sum_final;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_carry_msb;
  logic             r_cout;
  logic             r_ovf;

  // The single shared full-adder cell works on the operand LSBs and the carry FF.
  assign w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_out = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last      = (r_cnt == LAST_BIT);
  // The final sum includes the bit being produced on the edge that enters DONE.
  assign w_sum_final = {w_sum_bit, r_psum[WIDTH-1:1]};

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a Start in DONE is accepted just like in IDLE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          w_next   = S_ADD;
        end
      end
      S_ADD: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (Start) begin
          w_accept = 1'b1;
          w_next   = S_ADD;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/partial-sum shifting, carry tracking and result capture on the last bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a         <= '0;
      r_b         <= '0;
      r_psum      <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_carry_msb <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      r_a         <= A;
      r_b         <= B;
      r_psum      <= '0;
      r_cnt       <= '0;
      r_carry     <= Cin;
      r_carry_msb <= 1'b0;
    end else if (r_state == S_ADD) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_psum  <= w_sum_final;
      r_carry <= w_carry_out;
      // Carry leaving bit WIDTH-2 is the carry into the MSB, needed for signed overflow.
      if (r_cnt == MSB_FEEDER) begin
        r_carry_msb <= w_carry_out;
      end
      if (w_last) begin
        r_sum  <= w_sum_final;
        r_cout <= w_carry_out;
        r_ovf  <= r_carry_msb ^ w_carry_out;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign Busy     = (r_state == S_ADD);
  assign Done     = (r_state == S_DONE);
  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH 8 and 4
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .Start(start8), .A(a8), .B(b8), .Cin(cin8),
    .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8), .Overflow(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst), .Start(start4), .A(a4), .B(b4), .Cin(cin4),
    .Busy(busy4), .Done(done4), .Sum(sum4), .Cout(cout4), .Overflow(ovf4)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t m8_e, m4_e, last8;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done8 = -1;
  bit   b2b = 1'b0;

  always @(posedge clk) cyc++;

  // Reference: plain integer addition; signed overflow from operand/result signs.
  function automatic exp_t model(input int w, input int a, input int b, input int c);
    longint t;
    longint m;
    exp_t   e;
    bit     sa, sb, ss;
    m      = longint'(1) << w;
    t      = longint'(a) + longint'(b) + longint'(c);
    e.sum  = 32'(t % m);
    e.cout = (t >= m);
    sa     = (longint'(a) >= m / 2);
    sb     = (longint'(b) >= m / 2);
    ss     = (longint'(e.sum) >= m / 2);
    e.ovf  = (sa == sb) && (ss != sa);
    return e;
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    checks++;
    if (busy8 && done8) begin
      errors++;
      $display("FAIL busy_done8_overlap busy=%b done=%b required not both 1", busy8, done8);
    end
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected got Done=1 with no pending operation");
      end else begin
        m8_e = q8.pop_front();
        if (sum8 !== m8_e.sum[7:0] || cout8 !== m8_e.cout || ovf8 !== m8_e.ovf) begin
          errors++;
          $display("FAIL result8 got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                   sum8, cout8, ovf8, m8_e.sum[7:0], m8_e.cout, m8_e.ovf);
        end
      end
      if (b2b && last_done8 >= 0) begin
        checks++;
        if (cyc - last_done8 != 9) begin
          errors++;
          $display("FAIL done8_period got %0d cycles required 9", cyc - last_done8);
        end
      end
      last_done8 = cyc;
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (done4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL done4_unexpected got Done=1 with no pending operation");
      end else begin
        m4_e = q4.pop_front();
        if (sum4 !== m4_e.sum[3:0] || cout4 !== m4_e.cout || ovf4 !== m4_e.ovf || busy4) begin
          errors++;
          $display("FAIL result4 got sum=%h cout=%b ovf=%b busy=%b required sum=%h cout=%b ovf=%b busy=0",
                   sum4, cout4, ovf4, busy4, m4_e.sum[3:0], m4_e.cout, m4_e.ovf);
        end
      end
    end
  end

  // Issue one 8-bit add (DUT must be in IDLE or DONE); returns on the Done negedge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit hold);
    int n;
    int nb;
    bit got;
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = c;
    last8  = model(8, int'(a), int'(b), int'(c));
    q8.push_back(last8);
    @(posedge clk);
    n   = 0;
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (done8) begin
        got = 1'b1;
      end else begin
        if (busy8) nb++;
        start8 = hold ? 1'b1 : 1'($urandom);
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
      end
    end
    checks++;
    if (!got || n != 9 || nb != 8) begin
      errors++;
      $display("FAIL latency8 got done=%b after %0d cycles busy=%0d required done after 9, busy 8",
               got, n, nb);
    end
  endtask

  // Issue one 4-bit add with Start held; returns on the Done negedge.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int n;
    bit got;
    start4 = 1'b1;
    a4     = a;
    b4     = b;
    cin4   = c;
    q4.push_back(model(4, int'(a), int'(b), int'(c)));
    @(posedge clk);
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      n++;
      if (done4) got = 1'b1;
      else begin
        a4   = 4'($urandom);
        b4   = 4'($urandom);
        cin4 = 1'($urandom);
      end
    end
    checks++;
    if (!got || n != 5) begin
      errors++;
      $display("FAIL latency4 got done=%b after %0d cycles required done after 5", got, n);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  cin4 = 1'b0;
    #2;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8, busy4, done4, sum4, cout4, ovf4} !== '0) begin
      errors++;
      $display("FAIL reset_state got b8=%b d8=%b s8=%h c8=%b o8=%b b4=%b d4=%b s4=%h required all 0",
               busy8, done8, sum8, cout8, ovf8, busy4, done4, sum4);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, including a pass through IDLE before the first.
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h80, 8'h80, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    start8 = 1'b0;

    // Outputs hold while inputs wander with Start low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (sum8 !== last8.sum[7:0] || cout8 !== last8.cout || ovf8 !== last8.ovf || done8 !== 1'b0) begin
        errors++;
        $display("FAIL hold8 got sum=%h cout=%b ovf=%b done=%b required sum=%h cout=%b ovf=%b done=0",
                 sum8, cout8, ovf8, done8, last8.sum[7:0], last8.cout, last8.ovf);
      end
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
    end

    // Back-to-back random operations with Start held high.
    b2b        = 1'b1;
    last_done8 = -1;
    for (int i = 0; i < 12; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    b2b = 1'b0;

    // Known nonzero result, then asynchronous reset part-way through the next add.
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h77; cin8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== '0) begin
      errors++;
      $display("FAIL midreset8 got busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op8(8'h01, 8'h02, 1'b1, 1'b0);
    start8 = 1'b0;

    // Exhaustive WIDTH=4 sweep, back to back.
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      op4(4'(i), 4'(i >> 4), 1'(i >> 8));
    end
    start4 = 1'b0;

    repeat (12) @(negedge clk);
    checks++;
    if (q8.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL pending_results got q8=%0d q4=%0d required 0 and 0", q8.size(), q4.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that time-shares a single full-adder cell to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It owns operand and result shift registers, the carry flip-flop, a bit counter and a start/busy/done handshake. It sits above the one-bit full adder in the arithmetic library and is the area-minimal alternative to a ripple-carry adder.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 2..32
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- Start  input  1  request an addition; sampled on rising CLK edges
- A  input  WIDTH  operand A; sampled only on the accepting edge
- B  input  WIDTH  operand B; sampled only on the accepting edge
- Cin  input  1  carry-in; sampled only on the accepting edge
- Busy  output  1  high while bits are being processed
- Done  output  1  one-cycle pulse: result registers just updated
- Sum  output  WIDTH  registered result, held until the next Done
- Cout  output  1  registered carry-out of bit WIDTH-1
- Overflow  output  1  registered signed overflow: carry into MSB XOR Cout

## Operation

- States: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE: Start=1 accepts. Load the A and B shift registers, set carry FF = Cin, count = 0, go to ADD.
- ADD: the full-adder cell takes the LSB of each operand shift register and the carry FF.
  - Sum bit shifts into the MSB end of the partial-sum shift register; operands shift right by one.
  - Carry FF <= cell Cout. When count = WIDTH-2, capture the current carry FF as carry-into-MSB.
  - count increments. After the bit with count = WIDTH-1, go to DONE.
- DONE: Sum <= partial-sum register, Cout <= carry FF, Overflow <= carry-into-MSB XOR carry FF. These three registers load on the edge entering DONE. Done=1 for this cycle.
  - Start=1 in DONE is accepted exactly as in IDLE and goes straight to ADD, giving back-to-back operation.
  - Otherwise go to IDLE.
- Start in ADD is ignored. It is not queued, and A/B/Cin changes have no effect.
- Sum, Cout and Overflow change only on entry to DONE. Partial results never appear on the outputs.
- Arithmetic: {Cout,Sum} = A + B + Cin mod 2^(WIDTH+1). Overflow treats A, B and Sum as two's complement.
- Count width is clog2(WIDTH). The count never wraps past WIDTH-1 inside one operation.

## Timing

- Reset values: Busy=0, Done=0, Sum=0, Cout=0, Overflow=0, state IDLE. All internal registers are cleared.
- RST asserted at any time, including mid-ADD, aborts immediately and asynchronously. No Done is produced for the aborted operation.
- Start accepted at edge t0:
  - Busy=1 from t0 to t0+WIDTH.
  - Done=1 from t0+WIDTH to t0+WIDTH+1.
  - Result is valid from t0+WIDTH.
- Latency is WIDTH cycles from accepting edge to Done. Throughput with Start held high is one result per WIDTH+1 cycles.
- Busy and Done are never high together. Busy=0 in IDLE and DONE.
- Busy and Done are registered, decoded from state; no combinational path from Start.

## Test plan

- WIDTH=8: A=0x5A, B=0x3C, Cin=0 -> after 8 cycles Done pulses; Sum=0x96, Cout=0, Overflow=1. Busy high for exactly 8 cycles.
- WIDTH=8: A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1, Overflow=0. Then A=0x80, B=0x80, Cin=0 -> Sum=0x00, Cout=1, Overflow=1. Then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1, Overflow=0.
- Start held high continuously with new operands each DONE cycle:
  - Done pulses every 9 cycles.
  - Each result matches the operands presented on its accepting edge.
  - Pulses of Start and operand changes during Busy are ignored.
- Reset mid-operation: assert RST asynchronously (between edges) at bit 4 of an add -> Busy, Done, Sum, Cout and Overflow go to 0 immediately. After release, a fresh Start with A=0x01, B=0x02, Cin=1 gives Sum=0x04.
- Output hold: after a result, drive random A, B and Cin with Start=0 for 20 cycles -> Sum, Cout and Overflow unchanged; Done stays 0.
- WIDTH=4, exhaustive: all 512 combinations of A, B and Cin compared against a reference A+B+Cin and the signed-overflow model. Any mismatch fails the test.
